rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Arbiter for the single register-file write port. It shares the port between the in-order pipeline writeback stage and a buffered return path from the multi-cycle unit (multiply/divide). It sits after the writeback data-select mux and drives the register file's write enable, address and data. It also exports a pending-destination bitmap to the hazard unit and, optionally, a stall request that prevents the buffered path from starving.

## Interface
- DEPTH, 4: return-buffer entries, power of two, 2..16
- STARVE_LIMIT, 8: cycles the buffer head may wait before a stall is requested, 1..255
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; one clock, and the reset is synchronous and active-low
- wb_we  in  1  pipeline writeback valid
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline write data (output of writeback select mux)
- mdu_valid  in  1  multi-cycle result offered
- mdu_rd  in  5  multi-cycle destination register
- mdu_data  in  32  multi-cycle result
- mdu_ready  out  1  buffer can accept (count < DEPTH)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- busy  out  32  bit r set while any buffered entry targets r; bit 0 always 0
- stall_req  out  1  request pipeline freeze for one cycle (registered)

## Operation
- Pipeline wins. If wb_we=1 and wb_rd≠0, that write is issued.
- Otherwise, if the buffer is non-empty, the head is popped and issued.
- Otherwise nothing is issued: rf_we=0, and rf_waddr/rf_wdata hold their last values.
- wb_we=1 with wb_rd=0 is discarded and counts as a free slot, so the buffer may pop.
- Push occurs on mdu_valid && mdu_ready. An entry with mdu_rd=0 is handshaken but not stored.
- The buffer is a FIFO with wrapping read/write pointers (mod DEPTH) and a count of width clog2(DEPTH)+1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- mdu_ready = (count < DEPTH), derived from the registered count.
  - When full, mdu_ready=0 even if a pop happens in the same cycle; there is no full-bypass.
- busy is combinational: the OR of one-hot(rd) over valid entries. A bit clears in the cycle after the last matching entry pops.
- A pipeline write to a register also present in the buffer is issued normally. The hazard unit uses busy to prevent this ordering, and the block does not reorder.
- Starvation counter (see Configuration):
  - increments each cycle the buffer is non-empty and no pop occurs;
  - clears on any pop or when the buffer is empty;
  - when it reaches STARVE_LIMIT, stall_req=1 at the next edge for exactly one cycle, then the counter clears.
- Upstream guarantees wb_we=0 in the cycle following stall_req=1. If wb_we=1 anyway, the pipeline still wins and the counter restarts.

## Timing
- Pipeline path latency 1: wb_* sampled at edge t, rf_* valid after edge t.
- Buffer path minimum latency 2: push at edge t, pop decision in cycle t→t+1, rf_* valid after edge t+1. There is no pass-through from mdu_* to rf_*.
- Reset (rst_n=0 at a rising edge) sets:
  - rf_we=0, rf_waddr=0, rf_wdata=0;
  - count=0, both pointers=0, starvation counter=0, stall_req=0;
  - consequently busy=0 and mdu_ready=1 from the following cycle.
- Reset mid-operation drops all buffered entries without writing them. A handshake in the same cycle as reset is ignored.

## Configuration
- RF_WB_STARVE_GUARD_EN defined: the starvation counter and stall_req are implemented as above.
- Not defined: no counter is built, stall_req is tied to 0, and the buffer drains only in free slots.

## Test plan
- Reset, then wb_we=1, wb_rd=5, wb_data=0x1234_5678 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678; mdu_ready=1, busy=0.
- Push mdu_rd=9, data=0xDEAD_BEEF with wb_we=0 → busy[9]=1 the cycle after the push; rf_we=1, rf_waddr=9 one cycle later; busy[9]=0 afterwards.
- Hold wb_we=1, wb_rd=3 and push DEPTH=4 entries, then offer a 5th → mdu_ready=0 after the 4th push and the 5th is not taken. Release wb_we → entries are written in push order, one per cycle.
- Push and pop in the same cycle at count=2 → count stays 2 and pointers wrap correctly past entry 3.
- mdu_rd=0 push → handshake completes, busy unchanged, no rf write. wb_rd=0 with buffer non-empty → the head pops in that slot.
- With RF_WB_STARVE_GUARD_EN: one entry buffered, wb_we=1 with rd≠0 for 8 cycles → stall_req pulses for 1 cycle. Bench drops wb_we → head written the next cycle. Without the macro, stall_req stays 0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback, multi-cycle return and register-file port bundle
interface rf_wb_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;
  logic        stall_req;

  modport master (
    output wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, busy, stall_req
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, busy, stall_req
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write port arbiter, pipeline over buffered multi-cycle returns
// Optional starvation guard: RF_WB_STARVE_GUARD_EN
module rf_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic           clk,
  input logic           rst_n,
  rf_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic        wb_issue, pop, store;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic [31:0] busy_v;
  logic [PW-1:0] offs;

  assign bus.mdu_ready = (count < CW'(DEPTH));
  assign wb_issue      = bus.wb_we && (bus.wb_rd != 5'd0);
  assign pop           = !wb_issue && (count != '0);
  // Writes to x0 complete the handshake but never occupy a slot.
  assign store         = bus.mdu_valid && bus.mdu_ready && (bus.mdu_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rst_n && store) begin
      rd_mem[wr_ptr]   <= bus.mdu_rd;
      data_mem[wr_ptr] <= bus.mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= wb_issue || pop;
      if (wb_issue) begin
        rf_waddr_q <= bus.wb_rd;
        rf_wdata_q <= bus.wb_data;
      end else if (pop) begin
        rf_waddr_q <= rd_mem[rd_ptr];
        rf_wdata_q <= data_mem[rd_ptr];
      end
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    busy_v = '0;
    offs   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr;
      if (CW'(offs) < count) busy_v[rd_mem[i]] = 1'b1;
    end
    busy_v[0] = 1'b0;
  end

  assign bus.busy = busy_v;

`ifdef RF_WB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;
  logic       stall_q;
  logic       blocked;

  assign blocked = (count != '0) && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else if (!blocked) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else if (starve_cnt == 8'(STARVE_LIMIT - 1)) begin
      starve_cnt <= '0;
      stall_q    <= 1'b1;
    end else begin
      starve_cnt <= starve_cnt + 8'd1;
      stall_q    <= 1'b0;
    end
  end

  assign bus.stall_req = stall_q;
`else
  assign bus.stall_req = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed and random checks of rf_wb_arbiter against a queue model
module tb_rf_wb_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  ent_t        q[$];
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        exp_stall;
  int          streak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (q[i]) b[q[i].rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  task automatic post_checks(input string tag);
    chk({tag, ".rf_we"},     {31'd0, bus.rf_we},     {31'd0, exp_we});
    chk({tag, ".rf_waddr"},  {27'd0, bus.rf_waddr},  {27'd0, exp_addr});
    chk({tag, ".rf_wdata"},  bus.rf_wdata,           exp_data);
    chk({tag, ".stall_req"}, {31'd0, bus.stall_req}, {31'd0, exp_stall});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.wb_we     = 1'b1;
    bus.wb_rd     = 5'd4;
    bus.wb_data   = 32'hAAAA_5555;
    bus.mdu_valid = 1'b1;
    bus.mdu_rd    = 5'd17;
    bus.mdu_data  = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    q.delete();
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_stall = 1'b0;
    streak    = 0;
    post_checks(tag);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.wb_we     = 1'b0;
    bus.mdu_valid = 1'b0;
  endtask

  task automatic step(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    logic exp_ready;
    logic popped;
    int   size_before;
    @(negedge clk);
    bus.wb_we     = we;
    bus.wb_rd     = rd;
    bus.wb_data   = d;
    bus.mdu_valid = mv;
    bus.mdu_rd    = mrd;
    bus.mdu_data  = md;
    #1;
    exp_ready = (q.size() < DEPTH);
    chk({tag, ".mdu_ready"}, {31'd0, bus.mdu_ready}, {31'd0, exp_ready});
    chk({tag, ".busy"}, bus.busy, model_busy());

    size_before = q.size();
    popped = 1'b0;
    if (we && rd != 0) begin
      exp_we = 1'b1; exp_addr = rd; exp_data = d;
    end else if (q.size() != 0) begin
      ent_t e = q.pop_front();
      exp_we = 1'b1; exp_addr = e.rd; exp_data = e.data;
      popped = 1'b1;
    end else begin
      exp_we = 1'b0;
    end
    if (mv && exp_ready && mrd != 0) q.push_back('{rd: mrd, data: md});

`ifdef RF_WB_STARVE_GUARD_EN
    exp_stall = 1'b0;
    if (size_before != 0 && !popped) begin
      streak++;
      if (streak == STARVE_LIMIT) begin
        exp_stall = 1'b1;
        streak = 0;
      end
    end else begin
      streak = 0;
    end
`else
    exp_stall = 1'b0;
`endif

    @(posedge clk);
    #1;
    post_checks(tag);
  endtask

  initial begin
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_stall = 1'b0; streak = 0;

    do_reset("reset");

    step("wb_basic", 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);

    step("push9",   1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hDEAD_BEEF);
    step("pop9",    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("idle9",   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    for (int i = 0; i < DEPTH; i++)
      step("fill", 1'b1, 5'd3, 32'h3333_0000 + i, 1'b1, 5'(10 + i), 32'hC0DE_0000 + i);
    step("offer5", 1'b1, 5'd3, 32'h3333_00FF, 1'b1, 5'd20, 32'hFFFF_0005);
    step("drain0", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("drain1", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    for (int i = 0; i < 6; i++)
      step("pushpop", 1'b0, 5'd0, 32'd0, 1'b1, 5'(21 + i), 32'hABCD_0000 + i);
    for (int i = 0; i < 3; i++)
      step("drain2", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    step("rd0push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_0BAD);
    step("rd0idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("hold",    1'b1, 5'd6, 32'h6666_6666, 1'b1, 5'd12, 32'h1212_1212);
    step("wbrd0",   1'b1, 5'd0, 32'h0000_0001, 1'b0, 5'd0, 32'd0);

    step("starve_push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h1414_1414);
    for (int i = 0; i < STARVE_LIMIT; i++)
      step("starve_blk", 1'b1, 5'd7, 32'h7700_0000 + i, 1'b0, 5'd0, 32'd0);
    step("starve_rel", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("starve_idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic        we, mv;
      logic [4:0]  rd, mrd;
      if (i == 200) do_reset("reset_mid");
      we  = ($urandom_range(0, 99) < 65);
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mv  = ($urandom_range(0, 99) < 50);
      mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step("rand", we, rd, $urandom, mv, mrd, $urandom);
    end

    for (int i = 0; i < DEPTH + 1; i++)
      step("final_drain", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
